saturated_stream_fifo: RTL and testbench
========================================

Name: saturated_stream_fifo

Overview:
Output buffer directly downstream of the variable-precision round/saturate stage of the FIR output path. Accepts the 12-bit saturated sample stream and its 2-bit error channel. The upstream source has no backpressure. The block presents a ready/valid Avalon-ST source to the consumer (DAC/packetiser). It absorbs consumer stalls in a DEPTH-entry first-word-fall-through FIFO, flags overflow and reports fill level.

Parameters:
DATA_WIDTH, 12, sample width (matches saturator output)
ERROR_WIDTH, 2, Avalon-ST error channel width
DEPTH, 16, FIFO entries; power of two, minimum 4
ADDR_WIDTH, log2(DEPTH), pointer width; derived, not overridden

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
ast_sink_data  in  DATA_WIDTH  saturated sample
ast_sink_error  in  ERROR_WIDTH  error bits accompanying sample
ast_sink_valid  in  1  sample qualifier; no ready returned
ast_source_data  out  DATA_WIDTH  head-of-FIFO sample
ast_source_error  out  ERROR_WIDTH  head-of-FIFO error bits
ast_source_valid  out  1  FIFO non-empty
ast_source_ready  in  1  consumer accepts this cycle
overflow  out  1  sticky: sample dropped while full
overflow_clr  in  1  synchronous clear of overflow
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync-to-clk release assumed upstream) clears: write/read pointers = 0, level = 0, ast_source_valid = 0, overflow = 0. ast_source_data/error are don't-care while valid = 0. Memory is not reset.
- Storage: DEPTH words of {error, data}; pointers are ADDR_WIDTH+1 bits with a wrap bit. full = (level == DEPTH), empty = (level == 0).
- push = ast_sink_valid && (!full || pop). pop = ast_source_valid && ast_source_ready.
- Push writes at wr_ptr on the clock edge; the word is visible on the source one cycle later, with valid = 1. Latency is 1 cycle when empty.
- Source is FWFT: ast_source_data/error = mem[rd_ptr] while !empty; ast_source_valid = !empty, registered-equivalent (no combinational path from ast_sink_* to ast_source_*).
- Pop advances rd_ptr at the edge. The next word, if any, appears the following cycle with no bubble.
- level updates each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full and sink valid without pop: sample dropped, FIFO contents unchanged, overflow set at that edge.
- Full and sink valid with pop in the same cycle: push accepted, level stays DEPTH, no overflow.
- Empty with sink valid and ready high: no pop (valid = 0); word written, level becomes 1.
- overflow_clr clears overflow at the edge. If overflow_clr and a drop occur in the same cycle, set wins.
- Pointers wrap modulo 2*DEPTH; ordering is preserved across the wrap.
- Error bits travel with their sample; no modification.
- Reset asserted mid-stream: outputs go to reset values immediately. Buffered samples are discarded.

Decomposition:
- Shared package saturated_stream_pkg: DATA_WIDTH and ERROR_WIDTH constants, packed entry typedef {error, data}, clog2 helper for ADDR_WIDTH.
- One sub-module: saturated_stream_fifo_mem. Simple dual-port register array: write port (en, addr, word), asynchronous read port (addr). No reset.
- Top holds pointers, level counter, overflow flag and handshake logic.

Test Plan:
1. Reset with ast_sink_valid toggling -> ast_source_valid = 0, level = 0, overflow = 0 throughout reset and one cycle after release.
2. ready = 0; push 0x001/err0, 0x7FF/err1, 0x800/err2 -> level = 3. Raise ready -> source shows 0x001, 0x7FF, 0x800 on three consecutive cycles with matching errors. valid falls and level = 0 after the third.
3. ready = 0; push 16 words 0x100..0x10F, then 0xABC -> 0xABC dropped, overflow = 1, level = 16. Drain yields exactly 0x100..0x10F.
4. Full FIFO, ready = 1 and sink valid every cycle for 20 cycles -> level holds 16, overflow stays 0, output order matches input order.
5. Overflow set; assert overflow_clr alone -> overflow = 0 next cycle. Repeat with overflow_clr in the same cycle as a drop -> overflow remains 1.
6. ready = 1 continuously; stream 40 incrementing samples -> each appears exactly 1 cycle after input, level never exceeds 1, pointers wrap with no loss or duplication.

Source files
------------

// File: rtl/saturated_stream_pkg.sv
// Shared constants, entry layout and width helper for the saturated sample
// output buffer.
package saturated_stream_pkg;

  localparam int unsigned DATA_WIDTH    = 32'd12;
  localparam int unsigned ERROR_WIDTH   = 32'd2;
  localparam int unsigned DEFAULT_DEPTH = 32'd16;

  typedef struct packed {
    logic [ERROR_WIDTH-1:0] error;
    logic [DATA_WIDTH-1:0]  data;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result    = 32'd0;
    remaining = value - 32'd1;
    while (remaining != 32'd0) begin
      result    = result + 32'd1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/saturated_stream_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module saturated_stream_fifo_mem #(
  parameter int unsigned WORD_WIDTH = 32'd14,
  parameter int unsigned DEPTH      = 32'd16,
  parameter int unsigned ADDR_WIDTH = 32'd4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_word_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WORD_WIDTH-1:0] rd_word_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_word_i;
    end
  end

  assign rd_word_o = mem_q[rd_addr_i];

endmodule

// File: rtl/saturated_stream_fifo.sv
// First-word-fall-through buffer between the saturator (no backpressure) and a
// ready/valid consumer; tracks occupancy and latches sample drops.
module saturated_stream_fifo
  import saturated_stream_pkg::clog2;
#(
  parameter int unsigned DATA_WIDTH  = saturated_stream_pkg::DATA_WIDTH,
  parameter int unsigned ERROR_WIDTH = saturated_stream_pkg::ERROR_WIDTH,
  parameter int unsigned DEPTH       = saturated_stream_pkg::DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     ast_sink_data,
  input  logic [ERROR_WIDTH-1:0]    ast_sink_error,
  input  logic                      ast_sink_valid,
  output logic [DATA_WIDTH-1:0]     ast_source_data,
  output logic [ERROR_WIDTH-1:0]    ast_source_error,
  output logic                      ast_source_valid,
  input  logic                      ast_source_ready,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [clog2(DEPTH):0]     level
);

  localparam int unsigned ADDR_WIDTH = clog2(DEPTH);
  localparam int unsigned PTR_W      = ADDR_WIDTH + 32'd1;
  localparam int unsigned WORD_W     = DATA_WIDTH + ERROR_WIDTH;

  localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] LVL_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] LVL_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;

  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;

  saturated_stream_fifo_mem #(
    .WORD_WIDTH (WORD_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_s),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_word_i (wr_word_s),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_word_o (rd_word_s)
  );

  // Handshake decode and next-state for pointers, occupancy and the sticky flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;

    full_s    = (level_q == LVL_FULL);
    pop_s     = valid_q && ast_source_ready;
    push_s    = ast_sink_valid && (!full_s || pop_s);
    drop_s    = ast_sink_valid && full_s && !pop_s;
    wr_word_s = {ast_sink_error, ast_sink_data};

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear must stay visible.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    valid_d = (level_d != LVL_ZERO);
  end

  // State registers; buffered samples are discarded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {PTR_W{1'b0}};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign ast_source_data  = rd_word_s[DATA_WIDTH-1:0];
  assign ast_source_error = rd_word_s[WORD_W-1:DATA_WIDTH];
  assign ast_source_valid = valid_q;
  assign overflow         = overflow_q;
  assign level            = level_q;

endmodule

// File: tb/tb_saturated_stream_fifo.sv
// Directed bench for saturated_stream_fifo: a vector table for the basic
// handshake plus hand-written sequences for fill, overflow, wrap and reset.
module tb_saturated_stream_fifo;
  import saturated_stream_pkg::entry_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sink_data;
  logic [1:0]  sink_error;
  logic        sink_valid;
  logic [11:0] src_data;
  logic [1:0]  src_error;
  logic        src_valid;
  logic        src_ready;
  logic        ovf;
  logic        ovf_clr;
  logic [4:0]  level;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  saturated_stream_fifo dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ast_sink_data    (sink_data),
    .ast_sink_error   (sink_error),
    .ast_sink_valid   (sink_valid),
    .ast_source_data  (src_data),
    .ast_source_error (src_error),
    .ast_source_valid (src_valid),
    .ast_source_ready (src_ready),
    .overflow         (ovf),
    .overflow_clr     (ovf_clr),
    .level            (level)
  );

  typedef struct {
    logic        sv;
    logic [11:0] d;
    logic [1:0]  e;
    logic        rdy;
    logic        clr;
    logic        exp_v;
    logic [11:0] exp_d;
    logic [1:0]  exp_e;
    logic [4:0]  exp_lvl;
    logic        exp_ovf;
  } vec_t;

  vec_t   vecs [8];
  entry_t model_q [$];
  entry_t head;

  function automatic vec_t mk(input logic sv, input logic [11:0] d, input logic [1:0] e,
                              input logic rdy, input logic clr, input logic exp_v,
                              input logic [11:0] exp_d, input logic [1:0] exp_e,
                              input logic [4:0] exp_lvl, input logic exp_ovf);
    vec_t v;
    v.sv = sv; v.d = d; v.e = e; v.rdy = rdy; v.clr = clr;
    v.exp_v = exp_v; v.exp_d = exp_d; v.exp_e = exp_e;
    v.exp_lvl = exp_lvl; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [11:0] d, input logic [1:0] e);
    check({name, "_valid"}, {31'd0, src_valid}, 32'd1);
    check({name, "_data"},  {20'd0, src_data},  {20'd0, d});
    check({name, "_error"}, {30'd0, src_error}, {30'd0, e});
  endtask

  // Apply inputs at the falling edge, sample outputs just after the rising edge.
  task automatic drive(input logic sv, input logic [11:0] d, input logic [1:0] e,
                       input logic rdy, input logic clr);
    @(negedge clk);
    sink_valid = sv; sink_data = d; sink_error = e;
    src_ready  = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; sink_valid = 1'b0; sink_data = 12'h000; sink_error = 2'd0;
    src_ready = 1'b0; ovf_clr = 1'b0;

    vecs[0] = mk(1'b1, 12'h001, 2'd0, 1'b0, 1'b0, 1'b1, 12'h001, 2'd0, 5'd1, 1'b0);
    vecs[1] = mk(1'b1, 12'h7FF, 2'd1, 1'b0, 1'b0, 1'b1, 12'h001, 2'd0, 5'd2, 1'b0);
    vecs[2] = mk(1'b1, 12'h800, 2'd2, 1'b0, 1'b0, 1'b1, 12'h001, 2'd0, 5'd3, 1'b0);
    vecs[3] = mk(1'b0, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 12'h7FF, 2'd1, 5'd2, 1'b0);
    vecs[4] = mk(1'b0, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 12'h800, 2'd2, 5'd1, 1'b0);
    vecs[5] = mk(1'b0, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0, 12'h000, 2'd0, 5'd0, 1'b0);
    vecs[6] = mk(1'b1, 12'h123, 2'd3, 1'b1, 1'b0, 1'b1, 12'h123, 2'd3, 5'd1, 1'b0);
    vecs[7] = mk(1'b0, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0, 12'h000, 2'd0, 5'd0, 1'b0);

    // Test 1: reset held while the sink toggles, then one cycle after release.
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 12'h055, 2'd1, 1'b1, 1'b0);
      check("rst_valid", {31'd0, src_valid}, 32'd0);
      check("rst_level", {27'd0, level}, 32'd0);
      check("rst_ovf",   {31'd0, ovf}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1; sink_valid = 1'b0; src_ready = 1'b0;
    @(posedge clk); #1;
    check("rel_valid", {31'd0, src_valid}, 32'd0);
    check("rel_level", {27'd0, level}, 32'd0);
    check("rel_ovf",   {31'd0, ovf}, 32'd0);

    // Test 2 and empty+ready corner: table-driven.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].sv, vecs[i].d, vecs[i].e, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), {31'd0, src_valid}, {31'd0, vecs[i].exp_v});
      check($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].exp_lvl});
      check($sformatf("vec%0d_ovf", i),   {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_data", i),  {20'd0, src_data}, {20'd0, vecs[i].exp_d});
        check($sformatf("vec%0d_error", i), {30'd0, src_error}, {30'd0, vecs[i].exp_e});
      end
    end

    // Test 3: fill to 16, drop one, drain exactly the first 16.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 12'h100 + 12'(i), 2'(i), 1'b0, 1'b0);
    end
    check("fill_level", {27'd0, level}, 32'd16);
    check("fill_ovf",   {31'd0, ovf}, 32'd0);
    drive(1'b1, 12'hABC, 2'd3, 1'b0, 1'b0);
    check("drop_level", {27'd0, level}, 32'd16);
    check("drop_ovf",   {31'd0, ovf}, 32'd1);
    check_head("drop_head", 12'h100, 2'd0);
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("drain%0d", i), 12'h100 + 12'(i), 2'(i));
      drive(1'b0, 12'h000, 2'd0, 1'b1, 1'b0);
    end
    check("drained_valid", {31'd0, src_valid}, 32'd0);
    check("drained_level", {27'd0, level}, 32'd0);
    check("drained_ovf",   {31'd0, ovf}, 32'd1);

    // Test 5: clear alone, then clear colliding with a drop.
    drive(1'b0, 12'h000, 2'd0, 1'b0, 1'b1);
    check("clr_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 12'h300 + 12'(i), 2'(i + 1), 1'b0, 1'b0);
      model_q.push_back('{error: 2'(i + 1), data: 12'h300 + 12'(i)});
    end
    drive(1'b1, 12'hDEF, 2'd2, 1'b0, 1'b1);
    check("clr_drop_ovf",   {31'd0, ovf}, 32'd1);
    check("clr_drop_level", {27'd0, level}, 32'd16);
    check_head("clr_drop_head", 12'h300, 2'd1);
    drive(1'b0, 12'h000, 2'd0, 1'b0, 1'b1);
    check("reclr_ovf", {31'd0, ovf}, 32'd0);

    // Test 4: full FIFO with simultaneous push and pop for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      head = model_q[0];
      check_head($sformatf("fullpp%0d", k), head.data, head.error);
      drive(1'b1, 12'h200 + 12'(k), 2'(k), 1'b1, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back('{error: 2'(k), data: 12'h200 + 12'(k)});
      check($sformatf("fullpp%0d_level", k), {27'd0, level}, 32'd16);
      check($sformatf("fullpp%0d_ovf", k),   {31'd0, ovf}, 32'd0);
    end
    while (model_q.size() > 0) begin
      head = model_q[0];
      check_head("fulldrain", head.data, head.error);
      drive(1'b0, 12'h000, 2'd0, 1'b1, 1'b0);
      void'(model_q.pop_front());
    end
    check("fulldrain_valid", {31'd0, src_valid}, 32'd0);
    check("fulldrain_level", {27'd0, level}, 32'd0);

    // Test 6: streaming with ready held high across pointer wraps.
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 12'h400 + 12'(k), 2'(k), 1'b1, 1'b0);
      check_head($sformatf("stream%0d", k), 12'h400 + 12'(k), 2'(k));
      check($sformatf("stream%0d_level", k), {27'd0, level}, 32'd1);
    end
    drive(1'b0, 12'h000, 2'd0, 1'b1, 1'b0);
    check("stream_end_valid", {31'd0, src_valid}, 32'd0);
    check("stream_end_level", {27'd0, level}, 32'd0);

    // Reset asserted mid-stream acts immediately and discards the contents.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'h5A0 + 12'(i), 2'd1, 1'b0, 1'b0);
    end
    check("pre_rst_level", {27'd0, level}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, src_valid}, 32'd0);
    check("async_rst_level", {27'd0, level}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; sink_valid = 1'b0; src_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, src_valid}, 32'd0);
    check("post_rst_level", {27'd0, level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
